// File: rtl/pci_initiator_ctrl_if.sv
// pci_initiator_ctrl_if: core handshake and PCI bus signals of one initiator
interface pci_initiator_ctrl_if;
   logic        start;
   logic [3:0]  cmd;
   logic [31:0] addr;
   logic [2:0]  num_words;
   logic [31:0] wr_data;
   logic        wr_pop;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic        done;
   logic        abort;
   logic        REQ_n;
   logic        GNT_n;
   logic        frame_in;
   logic        irdy_in;
   logic        FRAME_n;
   logic        IRDY_n;
   logic        ctl_oe;
   logic        TRDY_n;
   logic        DEVSEL_n;
   logic [31:0] AD_out;
   logic [31:0] AD_in;
   logic        AD_oe;
   logic [3:0]  CBE_n;
   modport master (
      input  start, cmd, addr, num_words, wr_data, GNT_n, frame_in, irdy_in, TRDY_n, DEVSEL_n, AD_in,
      output wr_pop, rd_data, rd_valid, busy, done, abort, REQ_n, FRAME_n, IRDY_n, ctl_oe, AD_out, AD_oe, CBE_n
   );
   modport slave (
      output start, cmd, addr, num_words, wr_data, GNT_n, frame_in, irdy_in, TRDY_n, DEVSEL_n, AD_in,
      input  wr_pop, rd_data, rd_valid, busy, done, abort, REQ_n, FRAME_n, IRDY_n, ctl_oe, AD_out, AD_oe, CBE_n
   );
endinterface

// File: rtl/pci_initiator_ctrl.sv
// pci_initiator_ctrl: per-device PCI initiator sequencer (arbitration, address/data phases, master-abort)
module pci_initiator_ctrl #(
   parameter int MAX_BURST      = 4,
   parameter int DEVSEL_TIMEOUT = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   pci_initiator_ctrl_if.master bus
);
   typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, MABORT, TURN} state_t;
   localparam logic [2:0] MAX_W = 3'(MAX_BURST);
   localparam logic [7:0] TMO   = 8'(DEVSEL_TIMEOUT);
   state_t      state_q, state_d;
   logic [3:0]  cmd_q, cmd_d, cbe_n_q, cbe_n_d;
   logic [31:0] addr_q, addr_d, stg_q, stg_d, ad_out_q, ad_out_d, rd_data_q, rd_data_d;
   logic [2:0]  rem_q, rem_d, fet_q, fet_d, n_clamp;
   logic [7:0]  dcnt_q, dcnt_d;
   logic        stg_v_q, stg_v_d, dseen_q, dseen_d;
   logic        req_n_q, req_n_d, frame_n_q, frame_n_d, irdy_n_q, irdy_n_d, ctl_oe_q, ctl_oe_d, ad_oe_q, ad_oe_d;
   logic        rd_valid_q, rd_valid_d, wr_pop_q, wr_pop_d, busy_q, busy_d, done_q, done_d, abort_q, abort_d;
   logic        phase_ok, take;
   assign phase_ok = !bus.TRDY_n && !bus.DEVSEL_n;
   assign n_clamp  = bus.num_words > MAX_W ? MAX_W : bus.num_words;
   // Next-state and output decode; write words are prefetched one cycle ahead (wr_pop) into stg so zero-wait bursts stream
   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      addr_d     = addr_q;
      rem_d      = rem_q;
      fet_d      = fet_q - {2'b00, wr_pop_q};
      stg_d      = stg_q;
      stg_v_d    = stg_v_q;
      dcnt_d     = dcnt_q;
      dseen_d    = dseen_q;
      req_n_d    = req_n_q;
      frame_n_d  = frame_n_q;
      irdy_n_d   = irdy_n_q;
      ctl_oe_d   = ctl_oe_q;
      ad_out_d   = ad_out_q;
      ad_oe_d    = ad_oe_q;
      cbe_n_d    = cbe_n_q;
      rd_data_d  = rd_data_q;
      busy_d     = busy_q;
      rd_valid_d = 1'b0;
      done_d     = 1'b0;
      abort_d    = 1'b0;
      take       = 1'b0;
      case (state_q)
         IDLE: if (bus.start && bus.num_words != 3'd0) begin
            state_d = REQ;
            cmd_d   = bus.cmd;
            addr_d  = bus.addr;
            rem_d   = n_clamp;
            fet_d   = bus.cmd[0] ? n_clamp : 3'd0;
            stg_v_d = 1'b0;
            req_n_d = 1'b0;
            busy_d  = 1'b1;
         end
         REQ: if (!bus.GNT_n && bus.frame_in && bus.irdy_in) begin
            state_d   = ADDR;
            req_n_d   = 1'b1;
            frame_n_d = 1'b0;
            ctl_oe_d  = 1'b1;
            ad_oe_d   = 1'b1;
            ad_out_d  = addr_q;
            cbe_n_d   = cmd_q;
         end
         ADDR: begin
            state_d   = DATA;
            irdy_n_d  = 1'b0;
            cbe_n_d   = 4'h0;
            ad_oe_d   = cmd_q[0];
            frame_n_d = rem_q == 3'd1;
            dcnt_d    = 8'd0;
            dseen_d   = 1'b0;
            take      = cmd_q[0];
         end
         DATA: begin
            dseen_d = dseen_q | !bus.DEVSEL_n;
            if (phase_ok) begin
               rem_d     = rem_q - 3'd1;
               frame_n_d = rem_q <= 3'd2;
               take      = cmd_q[0] && rem_q != 3'd1;
               if (!cmd_q[0]) begin
                  rd_data_d  = bus.AD_in;
                  rd_valid_d = 1'b1;
               end
               if (rem_q == 3'd1) begin
                  state_d  = TURN;
                  irdy_n_d = 1'b1;
                  ad_oe_d  = 1'b0;
                  done_d   = 1'b1;
               end
            end else if (!dseen_q && bus.DEVSEL_n) begin
               dcnt_d = dcnt_q + 8'd1;
               if (dcnt_q == TMO - 8'd1) begin
                  state_d   = MABORT;
                  frame_n_d = 1'b1;
                  ad_oe_d   = 1'b0;
               end
            end
         end
         MABORT: begin
            state_d  = TURN;
            irdy_n_d = 1'b1;
            abort_d  = 1'b1;
         end
         TURN: begin
            state_d  = IDLE;
            ctl_oe_d = 1'b0;
            busy_d   = 1'b0;
            cbe_n_d  = 4'hF;
         end
         default: state_d = IDLE;
      endcase
      if (take) begin
         ad_out_d = stg_v_q ? stg_q : bus.wr_data;
         stg_v_d  = 1'b0;
      end else if (wr_pop_q) begin
         stg_d   = bus.wr_data;
         stg_v_d = 1'b1;
      end
      wr_pop_d = cmd_q[0] && fet_d != 3'd0 && !stg_v_d && (state_d == ADDR || state_d == DATA);
   end
   // State and registered outputs; reset releases the bus at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cmd_q      <= 4'h0;
         addr_q     <= 32'h0;
         rem_q      <= 3'd0;
         fet_q      <= 3'd0;
         stg_q      <= 32'h0;
         stg_v_q    <= 1'b0;
         dcnt_q     <= 8'd0;
         dseen_q    <= 1'b0;
         req_n_q    <= 1'b1;
         frame_n_q  <= 1'b1;
         irdy_n_q   <= 1'b1;
         ctl_oe_q   <= 1'b0;
         ad_out_q   <= 32'h0;
         ad_oe_q    <= 1'b0;
         cbe_n_q    <= 4'hF;
         rd_data_q  <= 32'h0;
         rd_valid_q <= 1'b0;
         wr_pop_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         abort_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         addr_q     <= addr_d;
         rem_q      <= rem_d;
         fet_q      <= fet_d;
         stg_q      <= stg_d;
         stg_v_q    <= stg_v_d;
         dcnt_q     <= dcnt_d;
         dseen_q    <= dseen_d;
         req_n_q    <= req_n_d;
         frame_n_q  <= frame_n_d;
         irdy_n_q   <= irdy_n_d;
         ctl_oe_q   <= ctl_oe_d;
         ad_out_q   <= ad_out_d;
         ad_oe_q    <= ad_oe_d;
         cbe_n_q    <= cbe_n_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         wr_pop_q   <= wr_pop_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         abort_q    <= abort_d;
      end
   end
   assign bus.REQ_n    = req_n_q;
   assign bus.FRAME_n  = frame_n_q;
   assign bus.IRDY_n   = irdy_n_q;
   assign bus.ctl_oe   = ctl_oe_q;
   assign bus.AD_out   = ad_out_q;
   assign bus.AD_oe    = ad_oe_q;
   assign bus.CBE_n    = cbe_n_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.wr_pop   = wr_pop_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.abort    = abort_q;
endmodule

// File: tb/tb_pci_initiator_ctrl.sv
// tb_pci_initiator_ctrl: directed checks of the PCI initiator sequencer
module tb_pci_initiator_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] k = 32'd0;
   logic [31:0] kb;
   int n_chk = 0, n_fail = 0, n_done = 0, n_abort = 0, n_rv = 0;
   int d0, a0, r0;
   pci_initiator_ctrl_if bif ();
   pci_initiator_ctrl #(.MAX_BURST(4), .DEVSEL_TIMEOUT(5)) dut (.clk(clk), .rst(rst), .bus(bif));
   always #5 clk = ~clk;
   // core write-data model: word k is presented until a wr_pop cycle ends
   assign bif.wr_data = 32'hD000_0000 + k;
   always @(posedge clk) if (bif.wr_pop === 1'b1) k <= k + 32'd1;
   // pulse counters (posedge sees the value held over the cycle just ending)
   always @(posedge clk) begin
      if (bif.done === 1'b1) n_done <= n_done + 1;
      if (bif.abort === 1'b1) n_abort <= n_abort + 1;
      if (bif.rd_valid === 1'b1) n_rv <= n_rv + 1;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask
   task automatic req(input logic [3:0] c, input logic [31:0] a, input logic [2:0] n);
      bif.start = 1'b1; bif.cmd = c; bif.addr = a; bif.num_words = n;
   endtask
   initial begin
      bif.start = 1'b0; bif.cmd = 4'h0; bif.addr = 32'h0; bif.num_words = 3'd0;
      bif.GNT_n = 1'b1; bif.frame_in = 1'b1; bif.irdy_in = 1'b1;
      bif.TRDY_n = 1'b1; bif.DEVSEL_n = 1'b1; bif.AD_in = 32'h0;
      tick(3);
      chk("rst_req_n", bif.REQ_n, 1); chk("rst_frame_n", bif.FRAME_n, 1); chk("rst_irdy_n", bif.IRDY_n, 1);
      chk("rst_ctl_oe", bif.ctl_oe, 0); chk("rst_ad_oe", bif.AD_oe, 0); chk("rst_ad_out", bif.AD_out, 0);
      chk("rst_cbe_n", bif.CBE_n, 4'hF); chk("rst_rd_data", bif.rd_data, 0); chk("rst_busy", bif.busy, 0);
      rst = 1'b0;
      tick;
      // zero-wait write burst of 3, grant withdrawn after the address phase
      kb = k; d0 = n_done;
      req(4'h7, 32'h100, 3'd3); bif.GNT_n = 1'b0; bif.TRDY_n = 1'b0; bif.DEVSEL_n = 1'b0;
      tick; bif.start = 1'b0;
      chk("wr_req_n", bif.REQ_n, 0); chk("wr_busy", bif.busy, 1); chk("wr_req_frame", bif.FRAME_n, 1);
      tick;
      chk("wr_addr_ad", bif.AD_out, 32'h100); chk("wr_addr_frame", bif.FRAME_n, 0); chk("wr_addr_cbe", bif.CBE_n, 4'h7);
      chk("wr_addr_ad_oe", bif.AD_oe, 1); chk("wr_addr_req_n", bif.REQ_n, 1); chk("wr_addr_ctl_oe", bif.ctl_oe, 1);
      bif.GNT_n = 1'b1;
      tick;
      chk("wr_d0_ad", bif.AD_out, 32'hD000_0000 + kb); chk("wr_d0_irdy", bif.IRDY_n, 0);
      chk("wr_d0_frame", bif.FRAME_n, 0); chk("wr_d0_cbe", bif.CBE_n, 4'h0);
      tick;
      chk("wr_d1_ad", bif.AD_out, 32'hD000_0001 + kb); chk("wr_d1_frame", bif.FRAME_n, 0);
      tick;
      chk("wr_d2_ad", bif.AD_out, 32'hD000_0002 + kb); chk("wr_d2_frame", bif.FRAME_n, 1); chk("wr_d2_irdy", bif.IRDY_n, 0);
      tick;
      chk("wr_turn_done", bif.done, 1); chk("wr_turn_irdy", bif.IRDY_n, 1); chk("wr_turn_frame", bif.FRAME_n, 1);
      chk("wr_turn_ctl_oe", bif.ctl_oe, 1); chk("wr_turn_ad_oe", bif.AD_oe, 0);
      tick;
      chk("wr_idle_busy", bif.busy, 0); chk("wr_idle_ctl_oe", bif.ctl_oe, 0); chk("wr_idle_done", bif.done, 0);
      chk("wr_pops", k - kb, 3); chk("wr_done_cnt", n_done - d0, 1);
      // read of 2 with two wait states on the first phase
      r0 = n_rv;
      req(4'h6, 32'h200, 3'd2); bif.GNT_n = 1'b0; bif.TRDY_n = 1'b1; bif.DEVSEL_n = 1'b0;
      tick; bif.start = 1'b0;
      tick;
      chk("rd_addr_ad", bif.AD_out, 32'h200); chk("rd_addr_cbe", bif.CBE_n, 4'h6);
      tick;
      chk("rd_w0_irdy", bif.IRDY_n, 0); chk("rd_w0_ad_oe", bif.AD_oe, 0); chk("rd_w0_frame", bif.FRAME_n, 0);
      tick;
      chk("rd_w1_irdy", bif.IRDY_n, 0); chk("rd_w1_rv", bif.rd_valid, 0); chk("rd_w1_ad_oe", bif.AD_oe, 0);
      tick;
      chk("rd_w2_irdy", bif.IRDY_n, 0);
      bif.TRDY_n = 1'b0; bif.AD_in = 32'hCAFE_0001;
      tick;
      chk("rd_p0_rv", bif.rd_valid, 1); chk("rd_p0_data", bif.rd_data, 32'hCAFE_0001);
      chk("rd_p1_frame", bif.FRAME_n, 1); chk("rd_p1_ad_oe", bif.AD_oe, 0);
      bif.AD_in = 32'hCAFE_0002;
      tick;
      chk("rd_p1_rv", bif.rd_valid, 1); chk("rd_p1_data", bif.rd_data, 32'hCAFE_0002); chk("rd_done", bif.done, 1);
      bif.TRDY_n = 1'b1;
      tick;
      chk("rd_rv_cnt", n_rv - r0, 2); chk("rd_idle_busy", bif.busy, 0);
      // busy bus: FRAME held by another master, then a grant gap and an IRDY-busy cycle
      kb = k;
      req(4'h7, 32'h300, 3'd1); bif.GNT_n = 1'b0; bif.frame_in = 1'b0; bif.TRDY_n = 1'b0; bif.DEVSEL_n = 1'b0;
      tick; bif.start = 1'b0;
      chk("bb_req_n", bif.REQ_n, 0);
      tick; chk("bb_wait1_frame", bif.FRAME_n, 1);
      tick; chk("bb_wait2_frame", bif.FRAME_n, 1);
      bif.frame_in = 1'b1; bif.GNT_n = 1'b1;
      tick; chk("bb_nognt_frame", bif.FRAME_n, 1); chk("bb_nognt_req_n", bif.REQ_n, 0);
      bif.GNT_n = 1'b0; bif.irdy_in = 1'b0;
      tick; chk("bb_irdy_frame", bif.FRAME_n, 1);
      bif.irdy_in = 1'b1;
      tick; chk("bb_addr_frame", bif.FRAME_n, 0); chk("bb_addr_ad", bif.AD_out, 32'h300);
      tick; chk("bb_d0_frame", bif.FRAME_n, 1); chk("bb_d0_irdy", bif.IRDY_n, 0); chk("bb_d0_ad", bif.AD_out, 32'hD000_0000 + kb);
      tick; chk("bb_done", bif.done, 1);
      tick;
      // master-abort on a read: DEVSEL never asserted
      d0 = n_done; a0 = n_abort; r0 = n_rv;
      req(4'h6, 32'h400, 3'd2); bif.GNT_n = 1'b0; bif.TRDY_n = 1'b0; bif.DEVSEL_n = 1'b1;
      tick; bif.start = 1'b0;
      tick;
      tick; chk("ma_d1_irdy", bif.IRDY_n, 0);
      tick(4);
      chk("ma_d5_frame", bif.FRAME_n, 0); chk("ma_d5_irdy", bif.IRDY_n, 0); chk("ma_d5_abort", bif.abort, 0);
      tick;
      chk("ma_frame", bif.FRAME_n, 1); chk("ma_irdy", bif.IRDY_n, 0); chk("ma_ad_oe", bif.AD_oe, 0); chk("ma_ctl_oe", bif.ctl_oe, 1);
      tick;
      chk("ma_turn_abort", bif.abort, 1); chk("ma_turn_done", bif.done, 0); chk("ma_turn_irdy", bif.IRDY_n, 1);
      tick;
      chk("ma_idle_busy", bif.busy, 0); chk("ma_abort_cnt", n_abort - a0, 1);
      chk("ma_done_cnt", n_done - d0, 0); chk("ma_rv_cnt", n_rv - r0, 0);
      // zero-length request is dropped
      bif.DEVSEL_n = 1'b0;
      req(4'h7, 32'h480, 3'd0);
      tick; bif.start = 1'b0;
      chk("nw0_req_n", bif.REQ_n, 1); chk("nw0_busy", bif.busy, 0);
      tick; chk("nw0_req_n2", bif.REQ_n, 1);
      // num_words=7 clamps to 4 phases; a start while busy is ignored
      kb = k; d0 = n_done;
      req(4'h7, 32'h500, 3'd7); bif.GNT_n = 1'b1;
      tick;
      chk("cl_req_n", bif.REQ_n, 0);
      bif.addr = 32'h900; bif.num_words = 3'd2;
      tick; bif.start = 1'b0; bif.GNT_n = 1'b0;
      tick; chk("cl_addr_ad", bif.AD_out, 32'h500);
      tick; chk("cl_d0_ad", bif.AD_out, 32'hD000_0000 + kb);
      tick(2); chk("cl_d2_frame", bif.FRAME_n, 0); chk("cl_d2_ad", bif.AD_out, 32'hD000_0002 + kb);
      tick; chk("cl_d3_frame", bif.FRAME_n, 1); chk("cl_d3_ad", bif.AD_out, 32'hD000_0003 + kb);
      tick; chk("cl_done", bif.done, 1);
      tick; chk("cl_idle_busy", bif.busy, 0); chk("cl_idle_req_n", bif.REQ_n, 1); chk("cl_pops", k - kb, 4);
      // start right after TURN is taken; reset mid-DATA releases the bus immediately
      d0 = n_done; a0 = n_abort;
      req(4'h7, 32'h600, 3'd3);
      tick; bif.start = 1'b0;
      chk("bk_req_n", bif.REQ_n, 0); chk("bk_busy", bif.busy, 1);
      tick;
      tick; chk("bk_d0_irdy", bif.IRDY_n, 0);
      rst = 1'b1;
      #1;
      chk("rs_frame", bif.FRAME_n, 1); chk("rs_irdy", bif.IRDY_n, 1); chk("rs_ad_oe", bif.AD_oe, 0);
      chk("rs_ctl_oe", bif.ctl_oe, 0); chk("rs_busy", bif.busy, 0); chk("rs_req_n", bif.REQ_n, 1);
      tick; rst = 1'b0;
      tick(2);
      chk("rs_idle_req_n", bif.REQ_n, 1); chk("rs_done_cnt", n_done - d0, 0); chk("rs_abort_cnt", n_abort - a0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
